obi_mmio_responder: RTL and testbench
=====================================

OBI_MMIO_RESPONDER -- requirements
Module: obi_mmio_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, 4 KiB-aligned base of the register window.
REQ-002 SHALL have parameter GNT_WAIT, default 0, the number of idle cycles between req_i assertion and gnt_o (range 0..15).
REQ-003 SHALL have port clk_i input 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni input 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_i input 1: request valid from the initiator.
REQ-006 SHALL have port gnt_o output 1: request accepted this cycle.
REQ-007 SHALL have port rvalid_o output 1: response valid (rdata_o, err_o qualified).
REQ-008 SHALL have port we_i input 1: 1=write, 0=read.
REQ-009 SHALL have port be_i input 4: byte enables for writes.
REQ-010 SHALL have port addr_i input 32: byte address.
REQ-011 SHALL have port wdata_i input 32: write data.
REQ-012 SHALL have port rdata_o output 32: read data.
REQ-013 SHALL have port err_o output 1: error response, valid with rvalid_o.
REQ-014 SHALL have port done_o output 1: high while FLAG != 0.
REQ-015 SHALL have port result_o output 32: current RESULT register.

Function
REQ-016 SHALL implement the register map: 0x0 FLAG rw; 0x4 RESULT rw; 0x8 CYCLES ro; 0xC STATUS ro (bit0 = done sticky, bits[15:8] = error count).
REQ-017 SHALL decode a hit when addr_i[31:12]==BASE_ADDR[31:12], addr_i[1:0]==0 and offset addr_i[11:2] is 0..3; every other access is an error.
REQ-018 SHALL respond to an error access with err_o=1 and rdata_o=0, and leave all registers unchanged.
REQ-019 SHALL treat a write to CYCLES or STATUS as an error.
REQ-020 SHALL update only the bytes of FLAG/RESULT whose be_i bit is 1; be_i=0000 is a legal no-op write with err_o=0.
REQ-021 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-022 FSM, IDLE: with req_i=1 and GNT_WAIT=0, assert gnt_o combinationally, latch the request and go to RESP; with GNT_WAIT>0, load the wait counter and go to WAIT.
REQ-023 FSM, WAIT: decrement the counter; gnt_o=1 in the cycle the counter reaches 0, latch the request and go to RESP.
REQ-024 FSM, RESP: rvalid_o=1 for exactly one cycle; go back to IDLE, except that with GNT_WAIT=0 and req_i=1 it grants the new request in the same cycle and stays in RESP (back-to-back, one response per cycle).
REQ-025 SHALL give a response latency of exactly 1 cycle after gnt_o; at most one request is outstanding.
REQ-026 SHALL commit a write at the gnt_o edge; a read in the same RESP cycle as an earlier write to the same register returns the written value.
REQ-027 SHALL only continue to grant if req_i stays asserted; a req_i drop in WAIT returns the FSM to IDLE with no gnt_o.
REQ-028 SHALL run CYCLES as a free-running 32-bit counter that wraps 0xFFFF_FFFF->0.
REQ-029 SHALL saturate the error count at 255.
REQ-030 SHALL set STATUS.done when FLAG becomes nonzero; it clears only on reset.
REQ-031 SHALL hold gnt_o, rvalid_o and err_o at 0 whenever the FSM is not in the corresponding state.

Reset
REQ-032 rst_ni=0 SHALL force state IDLE and set FLAG, RESULT, CYCLES, STATUS, rdata_o, gnt_o, rvalid_o, err_o and done_o to 0 immediately.
REQ-033 Reset during WAIT or RESP SHALL drop the in-flight transaction with no response and no register update.

Structure
REQ-034 A shared package SHALL hold the register offset constants, the FSM state enum and the error-count width.
REQ-035 SHALL be a single module with no sub-module; the wait counter and register file stay inline.

Verification
REQ-036 GNT_WAIT=0, write 0x4=0x0037_5F00 with be=1111, then read 0x4 -> gnt in the request cycle, rvalid 1 cycle later, rdata=0x0037_5F00, result_o=0x0037_5F00.
REQ-037 GNT_WAIT=3, read 0x8 -> gnt_o on the 4th cycle of req_i, rvalid the next cycle, rdata equal to the CYCLES value at the grant edge.
REQ-038 Write 0x0=1 -> done_o=1 and STATUS=0x1; then write 0x0=0 -> done_o=0, STATUS bit0 still 1.
REQ-039 Accesses to 0x10, to 0x2 and to an address outside the window, and a write to 0xC -> err_o=1, rdata=0 each time; STATUS[15:8]=4; after 300 errors it reads 255.
REQ-040 Write 0x4=0xFFFF_FFFF, then write 0x4=0x0000_00AB with be=0001 -> 0x4 reads 0xFFFF_FFAB.
REQ-041 Back-to-back reads with GNT_WAIT=0 over 4 cycles -> 4 consecutive rvalid pulses; asserting rst_ni=0 in WAIT -> no rvalid and registers read 0.

Source files
------------

// File: rtl/obi_mmio_responder_pkg.sv
// Shared definitions for the OBI MMIO responder: register word offsets,
// FSM state encoding and the width of the saturating error counter.
package obi_mmio_responder_pkg;

   // Word offsets (addr_i[11:2]) of the four registers in the window
   localparam logic [9:0] REG_FLAG   = 10'd0;
   localparam logic [9:0] REG_RESULT = 10'd1;
   localparam logic [9:0] REG_CYCLES = 10'd2;
   localparam logic [9:0] REG_STATUS = 10'd3;

   localparam int unsigned ERR_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/obi_mmio_responder.sv
// OBI-style MMIO responder exposing FLAG/RESULT/CYCLES/STATUS registers,
// with a configurable grant delay and single-cycle response after grant.
module obi_mmio_responder
   import obi_mmio_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int unsigned GNT_WAIT  = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        done_o,
   output logic [31:0] result_o
);

   state_t                 state_q, state_d;
   logic [3:0]             wait_q, wait_d;
   logic                   gnt;
   logic [31:0]            flag_q, result_q, cycles_q, rdata_q;
   logic [ERR_CNT_W-1:0]   err_cnt_q;
   logic                   done_q, err_q;
   logic [9:0]             word_off;
   logic                   hit, acc_err;
   logic [31:0]            rd_val, flag_new, result_new;
   logic                   flag_wr, result_wr;

   function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      gnt     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               if (GNT_WAIT == 0) begin
                  gnt     = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  wait_d  = 4'(GNT_WAIT - 1);
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // Initiator may withdraw while waiting; nothing was accepted yet
            if (!req_i) begin
               state_d = ST_IDLE;
            end else if (wait_q == 4'd0) begin
               gnt     = 1'b1;
               state_d = ST_RESP;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (GNT_WAIT == 0 && req_i) begin
               gnt     = 1'b1;
               state_d = ST_RESP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign word_off = addr_i[11:2];
   assign hit      = (addr_i[31:12] == BASE_ADDR[31:12]) && (addr_i[1:0] == 2'b00)
                     && (word_off <= REG_STATUS);
   assign acc_err  = !hit || (we_i && (word_off == REG_CYCLES || word_off == REG_STATUS));

   always_comb begin
      rd_val = 32'd0;
      unique case (word_off)
         REG_FLAG:   rd_val = flag_q;
         REG_RESULT: rd_val = result_q;
         REG_CYCLES: rd_val = cycles_q;
         REG_STATUS: rd_val = {{(24 - ERR_CNT_W){1'b0}}, err_cnt_q, 7'd0, done_q};
         default:    rd_val = 32'd0;
      endcase
   end

   assign flag_new   = apply_be(flag_q, wdata_i, be_i);
   assign result_new = apply_be(result_q, wdata_i, be_i);
   assign flag_wr    = gnt && we_i && !acc_err && (word_off == REG_FLAG);
   assign result_wr  = gnt && we_i && !acc_err && (word_off == REG_RESULT);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         wait_q    <= 4'd0;
         flag_q    <= 32'd0;
         result_q  <= 32'd0;
         cycles_q  <= 32'd0;
         rdata_q   <= 32'd0;
         err_cnt_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         cycles_q <= cycles_q + 32'd1;
         // Requests are accepted and writes committed on the grant edge
         if (gnt) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || we_i) ? 32'd0 : rd_val;
            if (acc_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
         end
         if (flag_wr) begin
            flag_q <= flag_new;
            if (flag_new != 32'd0) done_q <= 1'b1;
         end
         if (result_wr) result_q <= result_new;
      end
   end

   // gnt is combinational from req_i, so keep it quiet while reset is held
   assign gnt_o    = gnt & rst_ni;
   assign rvalid_o = (state_q == ST_RESP);
   assign err_o    = (state_q == ST_RESP) & err_q;
   assign rdata_o  = rdata_q;
   assign done_o   = (flag_q != 32'd0);
   assign result_o = result_q;

endmodule

// File: tb/tb_obi_mmio_responder.sv
// Bench for obi_mmio_responder: one instance with no grant delay, one with
// GNT_WAIT=3, driven by directed and random accesses against a register model.
module tb_obi_mmio_responder;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk;
   logic        rst_n;
   logic        req   [2];
   logic        we    [2];
   logic [3:0]  be    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [1:0]  gnt, rvalid, err, done;
   logic [31:0] rdata  [2];
   logic [31:0] result [2];

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference state
   logic [31:0] m_flag   [2];
   logic [31:0] m_result [2];
   bit          m_done   [2];
   int          m_err    [2];
   logic [31:0] tb_cyc;

   obi_mmio_responder #(.BASE_ADDR(BASE), .GNT_WAIT(0)) u_w0 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
      .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]),
      .err_o(err[0]), .done_o(done[0]), .result_o(result[0]));

   obi_mmio_responder #(.BASE_ADDR(BASE), .GNT_WAIT(3)) u_w3 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
      .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]),
      .err_o(err[1]), .done_o(done[1]), .result_o(result[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CYCLES reference: edges seen since reset released
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_cyc <= 32'd0;
      else        tb_cyc <= tb_cyc + 32'd1;
   end

   function automatic int gw(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_flag[d] = 0; m_result[d] = 0; m_done[d] = 0; m_err[d] = 0;
      end
   endtask

   // Applies one accepted access to the reference registers
   task automatic model_access(input int d, input bit w, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] cyc, output bit e, output logic [31:0] rd);
      int idx;
      bit in_win;
      logic [31:0] mask;
      in_win = ((a >> 12) == (BASE >> 12));
      idx = int'((a % 4096) / 4);
      e = !(in_win && (a % 4 == 0) && idx < 4) || (w && idx >= 2);
      rd = 0;
      if (e) begin
         if (m_err[d] < 255) m_err[d]++;
         return;
      end
      if (w) begin
         mask = 0;
         for (int k = 0; k < 4; k++) if (b[k]) mask |= (32'hFF << (8 * k));
         if (idx == 0) begin
            m_flag[d] = (m_flag[d] & ~mask) | (wd & mask);
            if (m_flag[d] != 0) m_done[d] = 1;
         end else begin
            m_result[d] = (m_result[d] & ~mask) | (wd & mask);
         end
      end else begin
         case (idx)
            0: rd = m_flag[d];
            1: rd = m_result[d];
            2: rd = cyc;
            default: rd = (m_err[d] << 8) | 32'(m_done[d]);
         endcase
      end
   endtask

   task automatic do_txn(input int d, input bit w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] wd, input string tag, output logic [31:0] rd);
      int n;
      bit got, ee;
      logic [31:0] ecyc, erd;
      @(negedge clk);
      req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
      n = 0; got = 0; ecyc = 0;
      while (!got && n < 20) begin
         #1; n++;
         if (gnt[d] === 1'b1) begin
            got = 1; ecyc = tb_cyc;
         end else begin
            @(negedge clk);
         end
      end
      chk({tag, "_lat"}, 32'(n), 32'(gw(d) + 1));
      rd = 0;
      if (!got) begin
         req[d] = 1'b0;
         return;
      end
      model_access(d, w, b, a, wd, ecyc, ee, erd);
      @(negedge clk);
      req[d] = 1'b0;
      #1;
      chk({tag, "_rvalid"}, 32'(rvalid[d]), 32'd1);
      chk({tag, "_err"}, 32'(err[d]), 32'(ee));
      if (!w || ee) chk({tag, "_rdata"}, rdata[d], erd);
      rd = rdata[d];
      @(negedge clk);
      #1;
      chk({tag, "_rvalid_drop"}, 32'(rvalid[d]), 32'd0);
      chk({tag, "_result_o"}, result[d], m_result[d]);
      chk({tag, "_done_o"}, 32'(done[d]), 32'(m_flag[d] != 0));
   endtask

   task automatic back_to_back();
      logic [31:0] alist [4];
      logic [31:0] exps  [4];
      bit e;
      alist[0] = BASE + 32'h4; alist[1] = BASE + 32'h0;
      alist[2] = BASE + 32'h8; alist[3] = BASE + 32'hC;
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'h0;
      for (int i = 0; i < 4; i++) begin
         addr[0] = alist[i];
         #1;
         chk("b2b_gnt", 32'(gnt[0]), 32'd1);
         if (i > 0) begin
            chk("b2b_rvalid", 32'(rvalid[0]), 32'd1);
            chk("b2b_rdata", rdata[0], exps[i-1]);
         end
         model_access(0, 1'b0, 4'h0, alist[i], 32'd0, tb_cyc, e, exps[i]);
         @(negedge clk);
      end
      req[0] = 1'b0;
      #1;
      chk("b2b_rvalid_last", 32'(rvalid[0]), 32'd1);
      chk("b2b_rdata_last", rdata[0], exps[3]);
      chk("b2b_gnt_off", 32'(gnt[0]), 32'd0);
      @(negedge clk);
      #1;
      chk("b2b_rvalid_drop", 32'(rvalid[0]), 32'd0);
   endtask

   logic [31:0] rd;
   logic [31:0] rtab [8];

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req[d] = 0; we[d] = 0; be[d] = 0; addr[d] = 0; wdata[d] = 0;
      end
      model_reset();
      #12;
      for (int d = 0; d < 2; d++) begin
         chk("rst_gnt", 32'(gnt[d]), 32'd0);
         chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
         chk("rst_err", 32'(err[d]), 32'd0);
         chk("rst_rdata", rdata[d], 32'd0);
         chk("rst_done", 32'(done[d]), 32'd0);
         chk("rst_result", result[d], 32'd0);
      end
      #10 rst_n = 1'b1;

      // Write/read RESULT, no grant delay
      do_txn(0, 1, 4'hF, BASE + 32'h4, 32'h0037_5F00, "w0_wr_result", rd);
      do_txn(0, 0, 4'h0, BASE + 32'h4, 32'h0, "w0_rd_result", rd);
      chk("w0_result_val", rd, 32'h0037_5F00);

      // CYCLES read with GNT_WAIT=3
      do_txn(1, 0, 4'h0, BASE + 32'h8, 32'h0, "w3_rd_cycles", rd);

      // done_o and sticky STATUS.done
      do_txn(0, 1, 4'hF, BASE + 32'h0, 32'h1, "w0_flag_set", rd);
      do_txn(0, 0, 4'h0, BASE + 32'hC, 32'h0, "w0_status1", rd);
      chk("status_eq1", rd, 32'h1);
      do_txn(0, 1, 4'hF, BASE + 32'h0, 32'h0, "w0_flag_clr", rd);
      do_txn(0, 0, 4'h0, BASE + 32'hC, 32'h0, "w0_status_sticky", rd);

      // Error accesses and saturating error count
      do_txn(0, 0, 4'h0, BASE + 32'h10, 32'h0, "err_off10", rd);
      do_txn(0, 0, 4'h0, BASE + 32'h2, 32'h0, "err_unaligned", rd);
      do_txn(0, 0, 4'h0, 32'h8000_1000, 32'h0, "err_outside", rd);
      do_txn(0, 1, 4'hF, BASE + 32'hC, 32'h55, "err_wr_status", rd);
      do_txn(0, 0, 4'h0, BASE + 32'hC, 32'h0, "status_cnt4", rd);
      chk("errcnt4", (rd >> 8) & 32'hFF, 32'd4);
      for (int i = 0; i < 300; i++) do_txn(0, 1, 4'hF, BASE + 32'h8, 32'h0, "err_loop", rd);
      do_txn(0, 0, 4'h0, BASE + 32'hC, 32'h0, "status_sat", rd);
      chk("errcnt_sat", (rd >> 8) & 32'hFF, 32'd255);

      // Byte enables
      do_txn(1, 1, 4'hF, BASE + 32'h4, 32'hFFFF_FFFF, "w3_be_all", rd);
      do_txn(1, 1, 4'h1, BASE + 32'h4, 32'h0000_00AB, "w3_be_low", rd);
      do_txn(1, 0, 4'h0, BASE + 32'h4, 32'h0, "w3_be_rd", rd);
      chk("be_merge", rd, 32'hFFFF_FFAB);
      do_txn(1, 1, 4'h0, BASE + 32'h4, 32'h1234_5678, "w3_be_none", rd);
      do_txn(1, 0, 4'h0, BASE + 32'h4, 32'h0, "w3_be_none_rd", rd);

      back_to_back();

      // Random accesses on both instances
      rtab[0] = BASE;          rtab[1] = BASE + 32'h4;  rtab[2] = BASE + 32'h8;
      rtab[3] = BASE + 32'hC;  rtab[4] = BASE + 32'h10; rtab[5] = BASE + 32'h2;
      rtab[6] = 32'h0000_2004; rtab[7] = BASE + 32'h4;
      for (int i = 0; i < 60; i++) begin
         do_txn(int'($urandom_range(0, 1)), 1'($urandom), 4'($urandom),
                rtab[$urandom_range(0, 7)], $urandom, "rand", rd);
      end

      // Withdrawn request during WAIT: no grant, no write
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = BASE + 32'h4; wdata[1] = 32'hDEAD_BEEF;
      #1 chk("drop_gnt_c1", 32'(gnt[1]), 32'd0);
      @(negedge clk);
      #1 chk("drop_gnt_c2", 32'(gnt[1]), 32'd0);
      @(negedge clk);
      req[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drop_gnt", 32'(gnt[1]), 32'd0);
         chk("drop_rvalid", 32'(rvalid[1]), 32'd0);
         @(negedge clk);
      end
      do_txn(1, 0, 4'h0, BASE + 32'h4, 32'h0, "drop_rd_result", rd);

      // Reset while waiting for the grant
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = BASE + 32'h4; wdata[1] = 32'h1234_5678;
      @(negedge clk);
      #1 chk("rstw_gnt_pre", 32'(gnt[1]), 32'd0);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rstw_rvalid", 32'(rvalid[1]), 32'd0);
      chk("rstw_result3", result[1], 32'd0);
      chk("rstw_result0", result[0], 32'd0);
      chk("rstw_done", 32'(done[1]), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("rstw_gnt_hold", 32'(gnt[1]), 32'd0);
         chk("rstw_rvalid_hold", 32'(rvalid[1]), 32'd0);
      end
      @(negedge clk);
      req[1] = 1'b0;
      rst_n = 1'b1;
      #1 chk("rstw_rvalid_post", 32'(rvalid[1]), 32'd0);
      do_txn(1, 0, 4'h0, BASE + 32'h4, 32'h0, "rstw_rd_result", rd);
      do_txn(1, 0, 4'h0, BASE + 32'h0, 32'h0, "rstw_rd_flag", rd);
      do_txn(1, 0, 4'h0, BASE + 32'hC, 32'h0, "rstw_rd_status", rd);
      do_txn(0, 0, 4'h0, BASE + 32'h4, 32'h0, "rstw_rd_result_w0", rd);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
